// File: rtl/bcd_pkg.sv
// Shared FSM encoding, 7-segment constants and helpers for bcd_ndisplays_seq.
package bcd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_LOAD  = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low {g,f,e,d,c,b,a}; entry i encodes decimal digit i.
   localparam logic [9:0][6:0] SEG_DIGIT = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_ndisplays_seq_seg7.sv
// One BCD digit to one active-low 7-segment pattern; non-decimal codes blank.
module seg7_decoder
   import bcd_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
   end

endmodule

// File: rtl/bcd_ndisplays_seq.sv
// Sequential double-dabble binary-to-BCD converter driving N_DIG 7-segment displays.
// Optional macro BCD_BLANK_LEADING_ZEROS_EN blanks leading zero digits (units always shown).
module bcd_ndisplays_seq
   import bcd_pkg::*;
#(
   parameter int N_IN  = 10,
   parameter int N_DIG = 4,
   parameter int N_OUT = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [N_IN-1:0]        bin_in,
   output logic                   busy,
   output logic                   done,
   output logic                   ovf,
   output logic [4*N_DIG-1:0]     bcd_out,
   output logic [N_DIG*N_OUT-1:0] seg_out
);

   localparam int ACC_W = 4*N_DIG + 4;
   localparam int CNT_W = $clog2(N_IN + 1);
   localparam longint unsigned MAX_IN = (64'd1 << N_IN) - 64'd1;
   // When the input range cannot reach 10^N_DIG the overflow path is dead logic.
   localparam bit OVF_POSSIBLE = (MAX_IN >= pow10(N_DIG));

   state_t                   state_q, state_d;
   logic [N_IN-1:0]          bin_q, bin_d;
   logic [ACC_W-1:0]         acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     carry_q, carry_d;
   logic [4*N_DIG-1:0]       bcd_q, bcd_d;
   logic [N_DIG*N_OUT-1:0]   seg_q, seg_d;
   logic                     ovf_q, ovf_d;
   logic                     done_q, done_d;

   logic [ACC_W-1:0]            acc_adj;
   logic [N_DIG-1:0][N_OUT-1:0] dec_seg;
   logic [N_DIG-1:0][N_OUT-1:0] seg_disp;
   logic                        ovf_now;

   for (genvar g = 0; g < N_DIG; g++) begin : g_dec
      seg7_decoder u_dec (
         .bcd_i (acc_q[4*g +: 4]),
         .seg_o (dec_seg[g])
      );
   end

   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < N_DIG + 1; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   assign ovf_now = OVF_POSSIBLE & (carry_q | (acc_q[ACC_W-1 -: 4] != 4'd0));

`ifdef BCD_BLANK_LEADING_ZEROS_EN
   logic lead;
   always_comb begin
      seg_disp = dec_seg;
      lead     = 1'b1;
      for (int i = N_DIG - 1; i > 0; i--) begin
         if (lead && acc_q[4*i +: 4] == 4'd0) seg_disp[i] = SEG_BLANK;
         else                                 lead        = 1'b0;
      end
   end
`else
   always_comb begin
      seg_disp = dec_seg;
   end
`endif

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      bcd_d   = bcd_q;
      seg_d   = seg_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               acc_d   = '0;
               carry_d = 1'b0;
               cnt_d   = CNT_W'(N_IN);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            acc_d   = {acc_adj[ACC_W-2:0], bin_q[N_IN-1]};
            carry_d = carry_q | acc_adj[ACC_W-1];
            bin_d   = bin_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ovf_d   = ovf_now;
            if (ovf_now) begin
               bcd_d = '1;
               seg_d = {N_DIG{SEG_DASH}};
            end else begin
               bcd_d = acc_q[4*N_DIG-1:0];
               seg_d = seg_disp;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         bcd_q   <= '0;
         seg_q   <= '1;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         bcd_q   <= bcd_d;
         seg_q   <= seg_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign bcd_out = bcd_q;
   assign seg_out = seg_q;

endmodule

// File: tb/tb_bcd_ndisplays_seq.sv
// Scoreboard bench: default 4-digit instance plus a 3-digit instance for overflow.
module tb_bcd_ndisplays_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start3;
   logic [9:0]  bin_in, bin3;
   logic        busy, done, ovf, busy3, done3, ovf3;
   logic [15:0] bcd_out;
   logic [27:0] seg_out;
   logic [11:0] bcd3;
   logic [20:0] seg3;

   bcd_ndisplays_seq dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy),
      .done(done), .ovf(ovf), .bcd_out(bcd_out), .seg_out(seg_out)
   );

   bcd_ndisplays_seq #(.N_IN(10), .N_DIG(3), .N_OUT(7)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin_in(bin3), .busy(busy3),
      .done(done3), .ovf(ovf3), .bcd_out(bcd3), .seg_out(seg3)
   );

   typedef struct {
      logic [15:0] bcd;
      logic [27:0] seg;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t q3[$];
   exp_t me, me3;
   int checks = 0, failures = 0, cyc = 0;

`ifdef BCD_BLANK_LEADING_ZEROS_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif
   localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int d;
      d = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   function automatic logic [27:0] ref_seg(input int v);
      logic [15:0] b;
      logic [27:0] s;
      logic [3:0]  d;
      logic        lead;
      b = ref_bcd(v);
      lead = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         d = b[4*i +: 4];
         s[7*i +: 7] = TBL[int'(d)];
         if (lead && d == 4'd0 && i > 0) s[7*i +: 7] = LZ;
         if (d != 4'd0) lead = 1'b0;
      end
      return s;
   endfunction

   // Monitors: pop one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            me = q.pop_front();
            chk("bcd_out", 64'(bcd_out), 64'(me.bcd));
            chk("seg_out", 64'(seg_out), 64'(me.seg));
            chk("ovf",     64'(ovf),     64'(me.ovf));
            chk("latency", 64'(cyc),     64'(me.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done3 === 1'b1) begin
         if (q3.size() == 0) begin
            checks++; failures++;
            $display("FAIL done3_unexpected actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            me3 = q3.pop_front();
            chk("bcd3",     64'(bcd3), 64'(me3.bcd[11:0]));
            chk("seg3",     64'(seg3), 64'(me3.seg[20:0]));
            chk("ovf3",     64'(ovf3), 64'(me3.ovf));
            chk("latency3", 64'(cyc),  64'(me3.cyc));
         end
      end
   end

   // Called at a negedge; returns at the negedge where the next start is back-to-back.
   task automatic conv(input int v, input logic [15:0] b, input logic [27:0] s, input logic o);
      bin_in = 10'(v);
      start  = 1'b1;
      q.push_back('{b, s, o, cyc + 12});
      @(negedge clk);
      start = 1'b0;
      chk("busy_hi", 64'(busy), 64'd1);
      repeat (11) @(negedge clk);
   endtask

   task automatic conv3(input int v, input logic [11:0] b, input logic [20:0] s, input logic o);
      bin3   = 10'(v);
      start3 = 1'b1;
      q3.push_back('{{4'h0, b}, {7'h00, s}, o, cyc + 12});
      @(negedge clk);
      start3 = 1'b0;
      repeat (11) @(negedge clk);
   endtask

   initial begin
      int v;
      int n;
      rst = 1'b1; start = 1'b0; start3 = 1'b0; bin_in = '0; bin3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy),    64'd0);
      chk("rst_done", 64'(done),    64'd0);
      chk("rst_ovf",  64'(ovf),     64'd0);
      chk("rst_bcd",  64'(bcd_out), 64'd0);
      chk("rst_seg",  64'(seg_out), 64'hFFFFFFF);
      chk("rst_seg3", 64'(seg3),    64'h1FFFFF);
      rst = 1'b0;

      conv(1023, 16'h1023, {7'h79, 7'h40, 7'h24, 7'h30}, 1'b0);
      conv(0,    16'h0000, {LZ, LZ, LZ, 7'h40},          1'b0);
      conv(1000, 16'h1000, {7'h79, 7'h40, 7'h40, 7'h40}, 1'b0);
      conv(305,  16'h0305, {LZ, 7'h30, 7'h40, 7'h12},    1'b0);
      conv(90,   16'h0090, {LZ, LZ, 7'h10, 7'h40},       1'b0);

      repeat (5) @(negedge clk);
      chk("hold_bcd", 64'(bcd_out), 64'h0090);
      chk("hold_seg", 64'(seg_out), 64'({LZ, LZ, 7'h10, 7'h40}));

      // start pulsed mid-conversion must be dropped
      bin_in = 10'd999; start = 1'b1;
      q.push_back('{16'h0999, {LZ, 7'h10, 7'h10, 7'h10}, 1'b0, cyc + 12});
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      bin_in = 10'd555; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);

      // start held high: second conversion samples the changed input
      bin_in = 10'd5; start = 1'b1;
      q.push_back('{16'h0005, {LZ, LZ, LZ, 7'h12}, 1'b0, cyc + 12});
      q.push_back('{16'h0007, {LZ, LZ, LZ, 7'h78}, 1'b0, cyc + 24});
      repeat (3) @(negedge clk);
      bin_in = 10'd7;
      repeat (12) @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);

      // reset mid-conversion aborts without done
      bin_in = 10'd777; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy),    64'd0);
      chk("abort_done", 64'(done),    64'd0);
      chk("abort_seg",  64'(seg_out), 64'hFFFFFFF);
      chk("abort_bcd",  64'(bcd_out), 64'd0);
      conv(42, 16'h0042, {LZ, LZ, 7'h19, 7'h24}, 1'b0);

      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(0, 1023));
         conv(v, ref_bcd(v), ref_seg(v), 1'b0);
      end

      conv3(1000, 12'hFFF, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
      conv3(999,  12'h999, {7'h10, 7'h10, 7'h10}, 1'b0);
      conv3(1023, 12'hFFF, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
      conv3(0,    12'h000, {LZ, LZ, 7'h40},       1'b0);

      n = 0;
      while ((q.size() != 0 || q3.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("sb_drain", 64'(q.size() + q3.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_ndisplays_seq.md
BCD_NDISPLAYS_SEQ -- requirements
Module: bcd_ndisplays_seq

Interface
REQ-001 The block SHALL have parameter N_IN, default 10, meaning the binary input width in bits (range 4..20).
REQ-002 The block SHALL have parameter N_DIG, default 4, meaning the number of decimal digits and displays (range 1..6).
REQ-003 The block SHALL have parameter N_OUT, default 7, meaning the segments per display (fixed at 7).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a conversion request, sampled on each clk edge.
REQ-007 The block SHALL have port bin_in, input, N_IN bits: the unsigned binary value, sampled when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the results are updated.
REQ-010 The block SHALL have port ovf, output, 1 bit: high when the last accepted value is >= 10^N_DIG.
REQ-011 The block SHALL have port bcd_out, output, 4*N_DIG bits: the packed BCD result, with the units digit in [3:0].
REQ-012 The block SHALL have port seg_out, output, N_DIG*N_OUT bits: active-low segments, units display in [6:0], each display ordered {g,f,e,d,c,b,a}.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and LOAD.
REQ-014 In IDLE, start=1 SHALL latch bin_in, clear the BCD accumulator, load the iteration counter with N_IN and enter SHIFT; start=0 SHALL keep the block in IDLE.
REQ-015 SHIFT SHALL perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left one bit with the binary MSB entering) and decrement the counter.
REQ-016 After the N_IN-th step the FSM SHALL enter LOAD, and LOAD SHALL return to IDLE after one cycle.
REQ-017 The accumulator SHALL be 4*N_DIG+4 bits wide; a nonzero guard nibble, or a carry-out beyond the guard, SHALL set overflow.
REQ-018 LOAD SHALL register bcd_out, seg_out and ovf and assert done for exactly that cycle.
REQ-019 Latency SHALL be N_IN+2 cycles from the start-accept edge to the edge at which done is high (12 cycles for the defaults).
REQ-020 busy SHALL be high in SHIFT and LOAD and low in IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored, not queued; start held high SHALL begin a new conversion on the first IDLE cycle after LOAD.
REQ-022 bcd_out, seg_out and ovf SHALL hold their values between done pulses.
REQ-023 If ovf=1, every display SHALL show a dash (7'h3F) and bcd_out SHALL be all-ones nibbles (4'hF).
REQ-024 Digit encoding SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, active-low), and blank=7F.

Reset
REQ-025 With rst=1 at a clk edge, the FSM SHALL go to IDLE with busy=0, done=0, ovf=0, bcd_out=0 and seg_out all-ones (blank).
REQ-026 rst SHALL override start on the same edge.
REQ-027 rst during SHIFT or LOAD SHALL abort the conversion without a done pulse, and the displays SHALL go blank.

Configuration
REQ-028 Macro BCD_BLANK_LEADING_ZEROS_EN, when defined, SHALL blank (7F) every zero digit more significant than the most significant nonzero digit; the units digit SHALL always be shown.
REQ-029 Without that macro, all N_DIG digits SHALL always be displayed, including leading zeros.
REQ-030 bcd_out SHALL be unaffected by the macro.

Structure
REQ-031 A shared package bcd_pkg SHALL hold the FSM state typedef, the 7-segment constants (digit table, dash, blank) and a function computing 10^N_DIG.
REQ-032 One sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out, combinational), SHALL be instantiated N_DIG times inside a generate loop.
REQ-033 The seg7_decoder outputs SHALL be registered in the top level on LOAD.

Verification
REQ-034 Reset then bin_in=1023 with a one-cycle start -> done 12 cycles later; bcd_out=16'h1023; seg_out displays {79,40,24,30}; ovf=0.
REQ-035 bin_in=0 -> bcd_out=0; seg_out all 40 without the macro; {7F,7F,7F,40} with BCD_BLANK_LEADING_ZEROS_EN.
REQ-036 With N_DIG=3, bin_in=1000 -> ovf=1, all displays 3F, bcd_out=12'hFFF; bin_in=999 -> ovf=0, bcd_out=12'h999.
REQ-037 start=1 with bin_in=5 held high, with bin_in changed to 7 during busy -> the first done shows 5, and the next accepted start samples 7.
REQ-038 rst pulsed at cycle 6 of a conversion -> no done pulse; busy=0 and seg_out all 7F on the next cycle; a new start then completes normally.
REQ-039 Random sweep of 0..1023 -> bcd_out matches the reference decimal conversion and done occurs exactly once per accepted start.
